prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Top-level run controller for the instruction-fetch stage.
- Drives the fetch stage's Init and ProgState inputs to load each program's start PC, releases the stage to run, and waits for its Halt flag.
- Steps through programs 0..NUM_PROGS-1 in order, then reports Done.
- A watchdog aborts the sequence if a program never halts.

Parameters:
- NUM_PROGS, 3, number of programs run per sequence; legal range 1..3 (ProgState codes 0..2).
- INIT_CYCLES, 2, cycles Init is held high per program before release; legal values >=1.
- TIMEOUT, 4096, maximum RUN cycles per program before watchdog abort; legal values >=2.
- CW, 16, width of the watchdog counter and the optional cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- CLK, input, 1, clock; all state changes on posedge.
- Init_n, input, 1, asynchronous active-low reset.
- Start, input, 1, one-cycle request to begin a sequence; sampled only in IDLE or DONE.
- Halt, input, 1, halt flag from the fetch stage; level-sampled.
- Init, output, 1, hold or load request to the fetch stage; 1 = PC loaded from ProgState.
- ProgState, output, 2, program select to the fetch stage.
- ProgIdx, output, 2, index of the current or most recent program.
- Busy, output, 1, high in LOAD and RUN.
- Done, output, 1, level-high in DONE.
- Timeout, output, 1, sticky watchdog flag; cleared only by reset or an accepted Start.
- RunCycles, output, CW, RUN-cycle count of the last completed program (optional feature).

Behaviour:
- Clock and reset: one clock, CLK. Init_n is asynchronous and active-low.
- Reset values: state=IDLE, Init=1, ProgState=0, ProgIdx=0, Busy=0, Done=0, Timeout=0, RunCycles=0, all counters 0.
- Output timing: all outputs are registered or decoded from the state register; no combinational path from Halt or Start to any output.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs: Init=1, ProgState=0.
  - Start=1 -> LOAD with ProgIdx=0, load counter cleared, Timeout cleared.
- LOAD:
  - Outputs: Init=1, ProgState=ProgIdx.
  - Load counter counts 0..INIT_CYCLES-1; at the terminal count -> RUN.
  - Watchdog counter cleared on entry.
  - Result: exactly INIT_CYCLES cycles with Init=1 per program.
- RUN:
  - Outputs: Init=0, ProgState=ProgIdx (held).
  - Watchdog increments every RUN cycle.
  - Halt=1 and ProgIdx<NUM_PROGS-1: ProgIdx+1, -> LOAD.
  - Halt=1 and ProgIdx=NUM_PROGS-1: -> DONE.
  - Halt=0 and watchdog=TIMEOUT-1: Timeout<=1, -> DONE; ProgIdx holds the failing program.
  - Halt=1 in the watchdog's terminal cycle: Halt wins, Timeout stays 0.
  - Halt is ignored in the first RUN cycle, because the fetch stage's Halt is registered and may still reflect a previous program.
- DONE:
  - Outputs: Init=1, ProgState=0, Done=1.
  - Start=1 -> LOAD with ProgIdx=0, Timeout<=0, Done<=0.
  - Otherwise stays in DONE.
- Start in LOAD or RUN: ignored, no queuing.
- Halt in IDLE, LOAD or DONE: ignored.
- Reset asserted mid-sequence: immediate return to reset values. Init=1 asynchronously, so the fetch stage is frozen.
- NUM_PROGS=1: RUN always exits to DONE on Halt.
- ProgIdx never exceeds NUM_PROGS-1.

Optional Feature:
- Macro: PROG_CYCLE_CNT_EN.
- When defined:
  - A CW-bit counter clears on RUN entry and increments every RUN cycle.
  - On a Halt-caused exit from RUN, RunCycles<=count, including the exit cycle.
  - On a timeout exit, RunCycles<=TIMEOUT.
  - RunCycles is held until the next update or reset.
- When not defined: RunCycles is tied to 0 and no counter logic exists.
- Port list is identical in both builds.

Test Plan:
- Reset: assert Init_n=0 mid-RUN of program 1 -> same cycle, Init=1, ProgIdx=0, Busy=0, Done=0, Timeout=0.
- Full sequence, NUM_PROGS=3, INIT_CYCLES=2, Halt pulsed on RUN cycle 10 of each program:
  - Init high exactly 2 cycles per program; ProgState sequence 0,1,2.
  - Done=1 after the third Halt, Timeout=0.
  - With PROG_CYCLE_CNT_EN, RunCycles=10.
- Watchdog, TIMEOUT=16, Halt never asserted in program 1:
  - After 16 RUN cycles: Done=1, Timeout=1, ProgIdx=1.
  - With PROG_CYCLE_CNT_EN, RunCycles=16.
- Collision: Halt=1 exactly on RUN cycle 16 with TIMEOUT=16 -> advance to the next program, Timeout=0.
- Start ignored and Halt gated:
  - Start pulsed during RUN of program 0 -> no effect on ProgIdx or state.
  - Halt held high during LOAD and the first RUN cycle -> no advance until the second RUN cycle.
- Restart from DONE with Timeout=1:
  - Start=1 -> next cycle: LOAD, ProgIdx=0, Timeout=0, Done=0, Init=1, ProgState=0.

Source files
------------

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - fetch-stage run controller; optional RUN-cycle counter under PROG_CYCLE_CNT_EN
module prog_sequencer #(
   parameter int NUM_PROGS   = 3,
   parameter int INIT_CYCLES = 2,
   parameter int TIMEOUT     = 4096,
   parameter int CW          = 16
) (
   input  logic          CLK,
   input  logic          Init_n,
   input  logic          Start,
   input  logic          Halt,
   output logic          Init,
   output logic [1:0]    ProgState,
   output logic [1:0]    ProgIdx,
   output logic          Busy,
   output logic          Done,
   output logic          Timeout,
   output logic [CW-1:0] RunCycles
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

   localparam int            LW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [LW-1:0] LOAD_LAST = LW'(INIT_CYCLES - 1);
   localparam logic [1:0]    LAST_IDX  = 2'(NUM_PROGS - 1);
   localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [LW-1:0] load_q, load_d;
   logic [CW-1:0] wd_q, wd_d;
   logic          to_q, to_d;
   logic          init_q, init_d;
   logic [1:0]    ps_q, ps_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef PROG_CYCLE_CNT_EN
   logic [CW-1:0] runc_q, runc_d;
`endif

   // Next-state logic; outputs are precomputed from the next state so they leave a flop
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load_d  = load_q;
      wd_d    = wd_q;
      to_d    = to_q;
`ifdef PROG_CYCLE_CNT_EN
      runc_d  = runc_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               state_d = S_LOAD;
               idx_d   = 2'd0;
               load_d  = '0;
               to_d    = 1'b0;
            end
         end
         S_LOAD: begin
            wd_d = '0;
            if (load_q == LOAD_LAST) begin
               state_d = S_RUN;
            end else begin
               load_d = load_q + LW'(1);
            end
         end
         S_RUN: begin
            wd_d = wd_q + CW'(1);
            // wd_q == 0 marks the first RUN cycle, where Halt may still be stale
            if (Halt && (wd_q != '0)) begin
`ifdef PROG_CYCLE_CNT_EN
               // the watchdog already counts RUN cycles from zero, so +1 includes this exit cycle
               runc_d = wd_q + CW'(1);
`endif
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  load_d  = '0;
                  state_d = S_LOAD;
               end
            end else if (wd_q == WD_LAST) begin
               to_d    = 1'b1;
               state_d = S_DONE;
`ifdef PROG_CYCLE_CNT_EN
               runc_d  = CW'(TIMEOUT);
`endif
            end
         end
      endcase

      init_d = (state_d != S_RUN);
      busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
      done_d = (state_d == S_DONE);
      ps_d   = busy_d ? idx_d : 2'd0;
   end

   // State and registered outputs; reset forces Init high at once to freeze the fetch stage
   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         load_q  <= '0;
         wd_q    <= '0;
         to_q    <= 1'b0;
         init_q  <= 1'b1;
         ps_q    <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef PROG_CYCLE_CNT_EN
         runc_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         load_q  <= load_d;
         wd_q    <= wd_d;
         to_q    <= to_d;
         init_q  <= init_d;
         ps_q    <= ps_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef PROG_CYCLE_CNT_EN
         runc_q  <= runc_d;
`endif
      end
   end

   assign Init      = init_q;
   assign ProgState = ps_q;
   assign ProgIdx   = idx_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Timeout   = to_q;
`ifdef PROG_CYCLE_CNT_EN
   assign RunCycles = runc_q;
`else
   assign RunCycles = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - randomized scenario bench for prog_sequencer against a program-level model
module tb_prog_sequencer;

   localparam int NP  = 3;
   localparam int IC  = 2;
   localparam int TMO = 16;
   localparam int CW  = 16;

   logic          CLK = 1'b0;
   logic          Init_n = 1'b0;
   logic          Start = 1'b0;
   logic          Halt = 1'b0;
   logic          Init;
   logic [1:0]    ProgState;
   logic [1:0]    ProgIdx;
   logic          Busy;
   logic          Done;
   logic          Timeout;
   logic [CW-1:0] RunCycles;

   int n_checks = 0;
   int n_errors = 0;

   int obs_load[4];
   int obs_run[4];
   int ps_seq[$];
   int hs[4];
   int exp_run[4];
   int exp_last;
   bit exp_to;

   prog_sequencer #(.NUM_PROGS(NP), .INIT_CYCLES(IC), .TIMEOUT(TMO), .CW(CW)) dut (
      .CLK(CLK), .Init_n(Init_n), .Start(Start), .Halt(Halt),
      .Init(Init), .ProgState(ProgState), .ProgIdx(ProgIdx), .Busy(Busy),
      .Done(Done), .Timeout(Timeout), .RunCycles(RunCycles)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   // Runs one sequence: hs[p] is the RUN cycle (1-based) on which Halt pulses in program p, 0 = never.
   // hold keeps Halt high throughout; poke pulses Start on RUN cycle 3 of program 0.
   task automatic run_seq(input string name, input int h0, input int h1, input int h2,
                          input bit hold, input bit poke);
      int  run_cnt;
      int  ridx;
      int  exp_rc;
      bit  prev_load;
      bit  ps_bad;
      bit  done_seen;
      bit  seq_ok;
      hs[0] = h0; hs[1] = h1; hs[2] = h2; hs[3] = 0;
      for (int i = 0; i < 4; i++) begin
         obs_load[i] = 0; obs_run[i] = 0; exp_run[i] = 0;
      end
      ps_seq.delete();
      // program-level model: a program ends on its Halt cycle if 2..TMO, otherwise times out
      exp_to = 1'b0;
      exp_last = 0;
      for (int p = 0; p < NP; p++) begin
         int len;
         len = hold ? 2 : hs[p];
         exp_last = p;
         if (len >= 2 && len <= TMO) begin
            exp_run[p] = len;
         end else begin
            exp_run[p] = TMO;
            exp_to = 1'b1;
            break;
         end
      end
`ifdef PROG_CYCLE_CNT_EN
      exp_rc = exp_run[exp_last];
`else
      exp_rc = 0;
`endif
      run_cnt = 0; prev_load = 0; ps_bad = 0; done_seen = 0;
      @(negedge CLK);
      Start = 1'b1;
      Halt  = hold;
      for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
         @(negedge CLK);
         Start = 1'b0;
         if (Done) begin
            done_seen = 1'b1;
         end else begin
            ridx = int'(ProgIdx);
            if (Busy && ProgState !== ProgIdx) ps_bad = 1'b1;
            if (Busy && Init) begin
               if (!prev_load) begin
                  ps_seq.push_back(int'(ProgState));
                  run_cnt = 0;
               end
               prev_load = 1'b1;
               obs_load[ridx]++;
            end else if (Busy) begin
               prev_load = 1'b0;
               run_cnt++;
               obs_run[ridx] = run_cnt;
            end
            Halt = hold || (Busy && !Init && run_cnt == hs[ridx]);
            if (poke && Busy && !Init && ridx == 0 && run_cnt == 3) Start = 1'b1;
         end
      end
      Halt = 1'b0;

      n_checks++;
      if (!done_seen) begin
         n_errors++; $display("FAIL %s done_reached: got 0 want 1 within cycle budget", name);
      end
      n_checks++;
      if (Timeout !== exp_to) begin
         n_errors++; $display("FAIL %s timeout_flag: got %0b want %0b", name, Timeout, exp_to);
      end
      n_checks++;
      if (int'(ProgIdx) != exp_last) begin
         n_errors++; $display("FAIL %s prog_idx: got %0d want %0d", name, ProgIdx, exp_last);
      end
      n_checks++;
      if (int'(RunCycles) != exp_rc) begin
         n_errors++; $display("FAIL %s run_cycles: got %0d want %0d", name, RunCycles, exp_rc);
      end
      n_checks++;
      if (ps_bad) begin
         n_errors++; $display("FAIL %s progstate_track: got ProgState!=ProgIdx want equal while busy", name);
      end
      for (int p = 0; p < NP; p++) begin
         n_checks++;
         if (obs_load[p] != ((p <= exp_last) ? IC : 0)) begin
            n_errors++;
            $display("FAIL %s init_cycles[%0d]: got %0d want %0d", name, p, obs_load[p],
                     (p <= exp_last) ? IC : 0);
         end
         n_checks++;
         if (obs_run[p] != exp_run[p]) begin
            n_errors++;
            $display("FAIL %s run_len[%0d]: got %0d want %0d", name, p, obs_run[p], exp_run[p]);
         end
      end
      seq_ok = (ps_seq.size() == exp_last + 1);
      for (int i = 0; i < ps_seq.size(); i++) if (ps_seq[i] != i) seq_ok = 1'b0;
      n_checks++;
      if (!seq_ok) begin
         n_errors++;
         $display("FAIL %s progstate_order: got %0d loads want 0..%0d in order", name, ps_seq.size(), exp_last);
      end
      n_checks++;
      if (Init !== 1'b1 || ProgState !== 2'd0 || Busy !== 1'b0 || Done !== 1'b1) begin
         n_errors++;
         $display("FAIL %s done_outputs: got Init=%0b PS=%0d Busy=%0b Done=%0b want 1 0 0 1",
                  name, Init, ProgState, Busy, Done);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      Init_n = 1'b0; Start = 1'b0; Halt = 1'b0;
      @(negedge CLK);
      Init_n = 1'b1;
   endtask

   task automatic test_reset();
      int  rc;
      bit  reached;
      Init_n = 1'b0;
      repeat (2) @(negedge CLK);
      n_checks++;
      if (Init !== 1'b1 || ProgState !== 2'd0 || ProgIdx !== 2'd0 || Busy !== 1'b0 ||
          Done !== 1'b0 || Timeout !== 1'b0 || RunCycles !== '0) begin
         n_errors++;
         $display("FAIL reset_values: got Init=%0b PS=%0d Idx=%0d Busy=%0b Done=%0b To=%0b RC=%0d want 1 0 0 0 0 0 0",
                  Init, ProgState, ProgIdx, Busy, Done, Timeout, RunCycles);
      end
      Init_n = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (Init !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
         n_errors++; $display("FAIL idle_after_reset: got Init=%0b Busy=%0b Done=%0b want 1 0 0", Init, Busy, Done);
      end
      // get into RUN of program 1, then reset asynchronously in mid-cycle
      Start = 1'b1;
      rc = 0; reached = 0;
      for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
         @(negedge CLK);
         Start = 1'b0;
         if (Busy && !Init) rc++; else rc = 0;
         Halt = (Busy && !Init && ProgIdx == 2'd0 && rc == 5);
         if (ProgIdx == 2'd1 && Busy && !Init && rc == 4) reached = 1'b1;
      end
      Halt = 1'b0;
      n_checks++;
      if (!reached) begin
         n_errors++; $display("FAIL reset_reach_prog1: got 0 want 1 within cycle budget");
      end
      #2;
      Init_n = 1'b0;
      #1;
      n_checks++;
      if (Init !== 1'b1 || ProgIdx !== 2'd0 || Busy !== 1'b0 || Done !== 1'b0 || Timeout !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_run: got Init=%0b Idx=%0d Busy=%0b Done=%0b To=%0b want 1 0 0 0 0",
                  Init, ProgIdx, Busy, Done, Timeout);
      end
      @(negedge CLK);
      Init_n = 1'b1;
   endtask

   task automatic test_full_sequence();
      run_seq("full_seq", 10, 10, 10, 1'b0, 1'b0);
   endtask

   task automatic test_watchdog();
      run_seq("watchdog", 6, 0, 9, 1'b0, 1'b0);
      n_checks++;
      if (Timeout !== 1'b1 || ProgIdx !== 2'd1 || Done !== 1'b1) begin
         n_errors++;
         $display("FAIL watchdog_abort: got To=%0b Idx=%0d Done=%0b want 1 1 1", Timeout, ProgIdx, Done);
      end
   endtask

   task automatic test_restart();
      @(negedge CLK);
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      n_checks++;
      if (Busy !== 1'b1 || Init !== 1'b1 || ProgIdx !== 2'd0 || Timeout !== 1'b0 ||
          Done !== 1'b0 || ProgState !== 2'd0) begin
         n_errors++;
         $display("FAIL restart_load: got Busy=%0b Init=%0b Idx=%0d To=%0b Done=%0b PS=%0d want 1 1 0 0 0 0",
                  Busy, Init, ProgIdx, Timeout, Done, ProgState);
      end
      repeat (IC) @(negedge CLK);
      n_checks++;
      if (Init !== 1'b0 || Busy !== 1'b1) begin
         n_errors++; $display("FAIL restart_run: got Init=%0b Busy=%0b want 0 1", Init, Busy);
      end
      do_reset();
   endtask

   task automatic test_collision();
      run_seq("collision", TMO, TMO, TMO, 1'b0, 1'b0);
   endtask

   task automatic test_halt_gating();
      run_seq("halt_gating", 0, 0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_seq("start_ignored", 8, 5, 3, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int a, b, c;
         a = $urandom_range(0, TMO + 3);
         b = $urandom_range(0, TMO + 3);
         c = $urandom_range(0, TMO + 3);
         run_seq($sformatf("random%0d", it), a, b, c, 1'b0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      run_seq("b2b_first", 2, 3, 4, 1'b0, 1'b0);
      run_seq("b2b_second", 12, 2, 15, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_watchdog();
      test_restart();
      test_collision();
      test_halt_gating();
      test_start_ignored();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
